cds_sample_capture: RTL and testbench

CDS_SAMPLE_CAPTURE -- requirements
Module: cds_sample_capture

---
 rtl/cds_sample_capture.sv | 161 ++++++++++++++++
 tb/tb_cds_sample_capture.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cds_sample_capture.sv
// Correlated double sampling capture.
// A trigger arms the block; the rising edge of cds_strobe captures the
// reset-level ADC sample and the falling edge captures the signal-level
// sample. The signed difference (reset minus signal) goes out through a
// valid/ready register. A new result that arrives while the previous one
// is still blocked is dropped and counted.
module cds_sample_capture #(
  parameter int ADC_W   = 14,
  parameter int TIMEOUT = 4095
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    trigger,
  input  logic                    cds_strobe,
  input  logic [ADC_W-1:0]        adc_data,
  input  logic                    out_ready,
  output logic signed [ADC_W:0]   cds_out,
  output logic                    out_valid,
  output logic                    timeout,
  output logic [7:0]              overrun_count
);

  // The wait counter only has to reach TIMEOUT-1: the abort decision is
  // taken in the cycle that would make it TIMEOUT.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    WAIT_SIG = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                 state;
  logic                   strobe_d;
  logic                   rise;
  logic                   fall;
  logic [ADC_W-1:0]       samp_rst;
  logic [ADC_W-1:0]       samp_sig;
  logic [CNT_W-1:0]       wait_cnt;
  logic                   done;
  logic                   load;
  logic                   drop;

  // Both samples are unsigned, so zero-extend by one bit before the
  // subtraction; the ADC_W+1 bit result then covers the full
  // -(2^ADC_W - 1) .. +(2^ADC_W - 1) range without overflow.
  function automatic logic signed [ADC_W:0] cds_diff(
    input logic [ADC_W-1:0] rst_lvl,
    input logic [ADC_W-1:0] sig_lvl
  );
    logic signed [ADC_W:0] rst_ext;
    logic signed [ADC_W:0] sig_ext;
    rst_ext = $signed({1'b0, rst_lvl});
    sig_ext = $signed({1'b0, sig_lvl});
    return rst_ext - sig_ext;
  endfunction

  // Saturating 8-bit increment: the overrun counter sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

  assign rise = cds_strobe & ~strobe_d;
  assign fall = ~cds_strobe & strobe_d;

  // The DONE cycle hands the captured pair to the output register. If the
  // previous result is still held and not being accepted this cycle, the
  // new one is dropped; otherwise it loads (even on the acceptance cycle).
  assign done = (state == DONE);
  assign load = done & (~out_valid | out_ready);
  assign drop = done & out_valid & ~out_ready;

  // One-cycle delayed copy of the strobe for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      strobe_d <= 1'b0;
    end else begin
      strobe_d <= cds_strobe;
    end
  end

  // Pixel-cycle sequencer: sample capture, wait timeout and abort handling.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      samp_rst <= '0;
      samp_sig <= '0;
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          // Strobe edges are meaningless until a pixel cycle starts.
          if (trigger) begin
            state    <= ARMED;
            wait_cnt <= '0;
          end
        end
        ARMED: begin
          // A repeated trigger simply restarts; a stray fall is ignored.
          if (trigger) begin
            state    <= ARMED;
            wait_cnt <= '0;
          end else if (rise) begin
            samp_rst <= adc_data;
            wait_cnt <= '0;
            state    <= WAIT_SIG;
          end
        end
        WAIT_SIG: begin
          // Trigger has priority over a coincident fall.
          if (trigger) begin
            state    <= ARMED;
            wait_cnt <= '0;
          end else if (fall) begin
            samp_sig <= adc_data;
            state    <= DONE;
          end else if (wait_cnt == CNT_LAST) begin
            state    <= IDLE;
            wait_cnt <= '0;
            timeout  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output register with valid/ready handshake; held steady while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cds_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (load) begin
        cds_out <= cds_diff(samp_rst, samp_sig);
      end
      out_valid <= load | (out_valid & ~out_ready);
    end
  end

  // Count results lost to back-pressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_count <= 8'd0;
    end else if (drop) begin
      overrun_count <= sat_inc8(overrun_count);
    end
  end

endmodule

// File: tb/tb_cds_sample_capture.sv
// Directed bench for cds_sample_capture with hand-computed expectations.
module tb_cds_sample_capture;

  localparam int ADC_W   = 14;
  localparam int TIMEOUT = 4095;

  logic                   clk;
  logic                   reset;
  logic                   trigger;
  logic                   cds_strobe;
  logic [ADC_W-1:0]       adc_data;
  logic                   out_ready;
  logic signed [ADC_W:0]  cds_out;
  logic                   out_valid;
  logic                   timeout;
  logic [7:0]             overrun_count;

  int n_cmp = 0;
  int n_err = 0;
  int tcount = 0;

  cds_sample_capture #(
    .ADC_W   (ADC_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .trigger       (trigger),
    .cds_strobe    (cds_strobe),
    .adc_data      (adc_data),
    .out_ready     (out_ready),
    .cds_out       (cds_out),
    .out_valid     (out_valid),
    .timeout       (timeout),
    .overrun_count (overrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of timeout pulses seen (one negedge per one-cycle pulse).
  always @(negedge clk) if (timeout) tcount++;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Full pixel cycle; returns in the cycle where the FSM sits in DONE.
  task automatic pixel(input int r, input int s, input int gap);
    trigger = 1'b1;
    step;
    trigger    = 1'b0;
    cds_strobe = 1'b1;
    adc_data   = ADC_W'(r);
    step;
    adc_data = '0;
    repeat (gap) step;
    cds_strobe = 1'b0;
    adc_data   = ADC_W'(s);
    step;
    adc_data = '0;
  endtask

  task automatic accept;
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first;
    int t0;
    reset      = 1'b0;
    trigger    = 1'b0;
    cds_strobe = 1'b0;
    adc_data   = '0;
    out_ready  = 1'b0;
    #3;
    check_eq("rst_cds_out", int'(cds_out), 0);
    check_eq("rst_valid", int'(out_valid), 0);
    check_eq("rst_timeout", int'(timeout), 0);
    check_eq("rst_overrun", int'(overrun_count), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Strobe edges in IDLE produce nothing.
    cds_strobe = 1'b1; adc_data = 14'd55; step;
    cds_strobe = 1'b0; step;
    repeat (3) step;
    check_eq("idle_ignore_valid", int'(out_valid), 0);

    // Nominal: 1000 - 400, valid exactly two cycles after the fall cycle.
    pixel(1000, 400, 92);
    check_eq("nom_lat_early", int'(out_valid), 0);
    step;
    check_eq("nom_valid", int'(out_valid), 1);
    check_eq("nom_result", int'(cds_out), 600);
    out_ready = 1'b1; step; out_ready = 1'b0;
    check_eq("nom_accept_clear", int'(out_valid), 0);

    // Negative extreme: 100 - 16383.
    pixel(100, 16383, 5); step;
    check_eq("neg_result", int'(cds_out), -16283);
    accept;

    // Positive extreme: 16383 - 0.
    pixel(16383, 0, 1); step;
    check_eq("pos_max_result", int'(cds_out), 16383);
    accept;
    check_eq("pos_max_clear", int'(out_valid), 0);

    // Timeout: rise and no fall.
    t0 = tcount;
    trigger = 1'b1; step; trigger = 1'b0;
    cds_strobe = 1'b1; adc_data = 14'd1234; step;
    first = -1;
    for (int i = 1; i <= 4200; i++) begin
      step;
      if (timeout) begin
        first = i;
        break;
      end
    end
    check_eq("timeout_latency", first, 4095);
    step;
    check_eq("timeout_width", int'(timeout), 0);
    check_eq("timeout_pulses", tcount - t0, 1);
    check_eq("timeout_no_valid", int'(out_valid), 0);
    cds_strobe = 1'b0; adc_data = 14'd7;
    repeat (4) step;
    check_eq("timeout_idle_fall", int'(out_valid), 0);

    // Back-pressure: second result dropped, first held.
    pixel(1000, 400, 3); step;
    check_eq("bp_first", int'(cds_out), 600);
    step;
    pixel(100, 50, 3); step;
    check_eq("bp_held", int'(cds_out), 600);
    check_eq("bp_valid", int'(out_valid), 1);
    check_eq("bp_overrun", int'(overrun_count), 1);
    accept;
    check_eq("bp_clear", int'(out_valid), 0);

    // New result coinciding with acceptance loads, nothing dropped.
    pixel(500, 100, 2); step;
    check_eq("coinc_first", int'(cds_out), 400);
    step;
    pixel(300, 100, 2);
    out_ready = 1'b1; step; out_ready = 1'b0;
    check_eq("coinc_valid", int'(out_valid), 1);
    check_eq("coinc_result", int'(cds_out), 200);
    check_eq("coinc_overrun", int'(overrun_count), 1);
    accept;

    // Abort with trigger in WAIT_SIG, then fresh 200/50.
    t0 = tcount;
    trigger = 1'b1; step; trigger = 1'b0;
    cds_strobe = 1'b1; adc_data = 14'd999; step;
    repeat (3) step;
    trigger = 1'b1; step; trigger = 1'b0;
    cds_strobe = 1'b0; adc_data = 14'd77; step;
    step;
    check_eq("abort_no_result", int'(out_valid), 0);
    cds_strobe = 1'b1; adc_data = 14'd200; step;
    repeat (2) step;
    cds_strobe = 1'b0; adc_data = 14'd50; step;
    step;
    check_eq("abort_valid", int'(out_valid), 1);
    check_eq("abort_result", int'(cds_out), 150);
    check_eq("abort_no_timeout", tcount - t0, 0);
    accept;

    // Trigger and fall together in WAIT_SIG: trigger wins, back in ARMED.
    trigger = 1'b1; step; trigger = 1'b0;
    cds_strobe = 1'b1; adc_data = 14'd700; step;
    step;
    trigger = 1'b1; cds_strobe = 1'b0; adc_data = 14'd1; step;
    trigger = 1'b0;
    repeat (3) step;
    check_eq("trig_fall_no_result", int'(out_valid), 0);
    cds_strobe = 1'b1; adc_data = 14'd40; step;
    cds_strobe = 1'b0; adc_data = 14'd10; step;
    step;
    check_eq("trig_fall_rearmed", int'(cds_out), 30);
    accept;

    // Trigger and rise together in IDLE: rise ignored.
    step;
    trigger = 1'b1; cds_strobe = 1'b1; adc_data = 14'd333; step;
    trigger = 1'b0;
    repeat (2) step;
    cds_strobe = 1'b0; adc_data = 14'd5; step;
    repeat (2) step;
    check_eq("trig_rise_ignored", int'(out_valid), 0);
    cds_strobe = 1'b1; adc_data = 14'd90; step;
    cds_strobe = 1'b0; adc_data = 14'd20; step;
    step;
    check_eq("trig_rise_result", int'(cds_out), 70);

    // Overrun counter saturates at 255 while 70 stays held.
    for (int i = 0; i < 260; i++) begin
      pixel(10, 5, 0);
      step;
    end
    check_eq("sat_overrun", int'(overrun_count), 255);
    check_eq("sat_held", int'(cds_out), 70);

    // Asynchronous reset in WAIT_SIG with a result pending.
    trigger = 1'b1; step; trigger = 1'b0;
    cds_strobe = 1'b1; adc_data = 14'd500; step;
    step;
    #1 reset = 1'b0;
    #1;
    check_eq("arst_cds_out", int'(cds_out), 0);
    check_eq("arst_valid", int'(out_valid), 0);
    check_eq("arst_timeout", int'(timeout), 0);
    check_eq("arst_overrun", int'(overrun_count), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    step;
    cds_strobe = 1'b0; adc_data = 14'd1; step;
    repeat (4) step;
    check_eq("arst_fall_ignored", int'(out_valid), 0);
    check_eq("arst_no_timeout", int'(timeout), 0);
    pixel(300, 100, 1); step;
    check_eq("arst_recover", int'(cds_out), 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
